y86_seq_ctrl: RTL

Multi-cycle stage sequencer for the Y86-64 SEQ core. Steps the existing fetch, decode, execute, memory and write-back logic one stage per clock, owns the architectural PC register and condition-code write enable, and selects the next PC. Detects halt, invalid-instruction and memory faults and freezes the machine with a Y86 status code. Sits between the top-level core wrapper and the stage modules; the stage modules stay combinational or clocked exactly as today, gated by this block's enables.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_pc_select.sv | 34 +++
 rtl/y86_seq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ sequencer: instruction codes, status
// encoding, sequencer states and next-PC select.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_STOP
  } state_t;

  typedef enum logic [1:0] {
    PC_SEL_VALP, PC_SEL_VALC, PC_SEL_VALM
  } pc_sel_t;

  // Instructions that touch data memory and therefore need the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET) || (ic == IPUSHQ) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_pc_select.sv
// Combinational next-PC mux: call and taken jumps go to valC, ret to valM,
// everything else falls through to valP.
module y86_pc_select
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] new_pc
);

  pc_sel_t pc_sel;

  always_comb begin
    pc_sel = PC_SEL_VALP;
    if ((icode == ICALL) || ((icode == IJXX) && cnd)) begin
      pc_sel = PC_SEL_VALC;
    end else if (icode == IRET) begin
      pc_sel = PC_SEL_VALM;
    end
  end

  always_comb begin
    new_pc = valP;
    case (pc_sel)
      PC_SEL_VALC: new_pc = valC;
      PC_SEL_VALM: new_pc = valM;
      default:     new_pc = valP;
    endcase
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: steps one stage per
// clock, owns the PC and retire count, and freezes with a status on faults.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        instruct_err,
  input  logic        mem_err,
  input  logic        mem_ready,
  output logic [63:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        cc_we,
  output logic [1:0]  stat,
  output logic        halted,
  output logic [31:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [1:0]        stat_reg, stat_next;
  logic [63:0]       pc_reg, pc_next;
  logic [31:0]       retired_reg, retired_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [63:0]       new_pc;

  y86_pc_select u_pc_select (
    .icode  (icode),
    .cnd    (cnd),
    .valC   (valC),
    .valP   (valP),
    .valM   (valM),
    .new_pc (new_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      stat_reg    <= STAT_AOK;
      pc_reg      <= RESET_PC;
      retired_reg <= 32'd0;
      wait_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      stat_reg    <= stat_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      wait_reg    <= wait_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stat_next    = stat_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    wait_next    = wait_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        // Invalid instruction outranks an address fault in the same cycle.
        if (instruct_err) begin
          stat_next  = STAT_INS;
          state_next = S_STOP;
        end else if (mem_err) begin
          stat_next  = STAT_ADR;
          state_next = S_STOP;
        end else if (icode == IHALT) begin
          stat_next  = STAT_HLT;
          state_next = S_STOP;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        wait_next  = '0;
        state_next = is_mem_icode(icode) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // A ready on the last allowed cycle still completes the access.
        if (mem_err) begin
          stat_next  = STAT_ADR;
          state_next = S_STOP;
          wait_next  = '0;
        end else if (mem_ready) begin
          state_next = S_WRITEBACK;
          wait_next  = '0;
        end else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
          stat_next  = STAT_ADR;
          state_next = S_STOP;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD: begin
        pc_next      = new_pc;
        retired_next = retired_reg + 32'd1;
        state_next   = S_FETCH;
      end
      S_STOP: state_next = S_STOP;
      default: state_next = S_IDLE;
    endcase
  end

  assign fetch_en  = (state_reg == S_FETCH);
  assign decode_en = (state_reg == S_DECODE);
  assign exec_en   = (state_reg == S_EXECUTE);
  assign mem_en    = (state_reg == S_MEMORY);
  assign wb_en     = (state_reg == S_WRITEBACK);
  assign cc_we     = (state_reg == S_EXECUTE) && (icode == IOPQ);
  assign pc        = pc_reg;
  assign stat      = stat_reg;
  assign halted    = (stat_reg != STAT_AOK);
  assign retired   = retired_reg;

endmodule
